pattern_ctrl: RTL
=================

PATTERN_CTRL -- requirements
Module: pattern_ctrl

Interface
REQ-001 SHALL have parameter NUM_PATTERNS, default 5, number of selectable test patterns (pattern_sel range 0..NUM_PATTERNS-1).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000, clk cycles a synchronized button level must stay stable before acceptance.
REQ-003 SHALL have parameter SCROLL_STEP, default 8, pixels added/subtracted from scroll_x per left/right press.
REQ-004 SHALL have parameter AUTO_FRAMES, default 300, frame count used by auto-cycle.
REQ-005 clk  input  1  pixel clock; reset reset, asynchronous, active-high; clock clk.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 btn_up, btn_down, btn_left, btn_right  input  1 each  raw asynchronous push buttons, active-high.
REQ-008 frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-009 pattern_sel  output  3  registered pattern index for the graphics block.
REQ-010 scroll_x  output  10  registered horizontal pattern offset, 0..639.
REQ-011 update_pulse  output  1  one-cycle pulse when pattern_sel or scroll_x changed.
REQ-012 auto_active  output  1  high while controller is in AUTO state.

Function
REQ-013 Each button SHALL pass a 2-FF synchronizer, then a debouncer whose accepted level updates only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-014 A 0->1 transition of an accepted level SHALL set that button's pending flag; flags stay set until the next frame_start.
REQ-015 On a frame_start cycle, all pending flags SHALL be applied and cleared; outputs update on the following clock edge (latency 1).
REQ-016 A press accepted in the same cycle as frame_start SHALL remain pending for the next frame.
REQ-017 up SHALL increment pattern_sel, wrapping NUM_PATTERNS-1 -> 0; down SHALL decrement, wrapping 0 -> NUM_PATTERNS-1.
REQ-018 up and down pending together SHALL cancel; pattern_sel unchanged.
REQ-019 right SHALL set scroll_x to (scroll_x+SCROLL_STEP) mod 640; left to (scroll_x-SCROLL_STEP) mod 640; both pending SHALL cancel.
REQ-020 update_pulse SHALL assert for exactly the one cycle in which an output value actually changed; never when a cancel left outputs unchanged.
REQ-021 Outputs SHALL NOT change at any time other than the cycle after frame_start.
REQ-022 State machine: MANUAL (reset state) and AUTO; auto_active = (state==AUTO).

Reset
REQ-023 reset SHALL immediately set pattern_sel=0, scroll_x=0, update_pulse=0, auto_active=0, state=MANUAL, clear pending flags, synchronizers, debounce counters and accepted levels (released), and the frame idle counter.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count; a button held through reset release SHALL register one press after DEBOUNCE_CYCLES.

Configuration
REQ-025 Macro PATTERN_CTRL_AUTO_CYCLE_EN defined: frame idle counter counts frame_start pulses with no pending flags; at AUTO_FRAMES go MANUAL->AUTO and reset count; in AUTO, every AUTO_FRAMES frames pattern_sel increments with wrap and update_pulse fires; any accepted press returns to MANUAL, clears the count, and its action is applied at the next frame_start.
REQ-026 Macro undefined: no idle counter, state fixed MANUAL, auto_active tied 0.

Structure
REQ-027 Shared package vga_pkg SHALL hold H_ACTIVE=640, V_ACTIVE=480, pattern ID constants (PAT_HBANDS=0, PAT_VBANDS=1, PAT_CHECKER=2, PAT_BOX=3, PAT_SOLID=4) and 3-bit RGB colour constants.
REQ-028 Sub-module btn_debounce (synchronizer + debounce + rising-edge output) SHALL be instantiated four times.

Verification (DEBOUNCE_CYCLES=4, AUTO_FRAMES=3)
REQ-029 btn_up high 10 cycles, then frame_start -> pattern_sel 0->1 one cycle later, update_pulse one cycle.
REQ-030 pattern_sel=0, btn_down press, frame_start -> pattern_sel=4; btn_left at scroll_x=0 -> scroll_x=632.
REQ-031 btn_up glitch 2 cycles -> no pending, no change at frame_start; up+down both pending -> no change, update_pulse stays 0.
REQ-032 Press accepted in frame_start cycle -> no change that frame, applied at next frame_start.
REQ-033 Macro defined, 3 idle frames -> auto_active=1; 3 more -> pattern_sel+1; btn_right press -> auto_active=0, scroll_x=8 at next frame_start.
REQ-034 reset asserted with pattern_sel=3, scroll_x=16, state AUTO -> all outputs 0 immediately, held button yields one press after release.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg -- constants shared by the VGA test-pattern blocks.
//
// Contents:
//   H_ACTIVE / V_ACTIVE   visible resolution (640x480)
//   PAT_*                 pattern identifiers driven on pattern_sel
//   RGB_*                 3-bit colour codes {r,g,b}
//   BTN_*                 bit positions of the four buttons in a button vector
//   ctrl_state_t          controller state (MANUAL / AUTO)
//   scroll_step()         modulo-H_ACTIVE horizontal offset step
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [2:0] PAT_HBANDS  = 3'd0;
  localparam logic [2:0] PAT_VBANDS  = 3'd1;
  localparam logic [2:0] PAT_CHECKER = 3'd2;
  localparam logic [2:0] PAT_BOX     = 3'd3;
  localparam logic [2:0] PAT_SOLID   = 3'd4;

  localparam logic [2:0] RGB_BLACK   = 3'b000;
  localparam logic [2:0] RGB_BLUE    = 3'b001;
  localparam logic [2:0] RGB_GREEN   = 3'b010;
  localparam logic [2:0] RGB_CYAN    = 3'b011;
  localparam logic [2:0] RGB_RED     = 3'b100;
  localparam logic [2:0] RGB_MAGENTA = 3'b101;
  localparam logic [2:0] RGB_YELLOW  = 3'b110;
  localparam logic [2:0] RGB_WHITE   = 3'b111;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } ctrl_state_t;

  // Moves x by step pixels left or right, wrapping inside 0..H_ACTIVE-1.
  // step must be smaller than H_ACTIVE.
  function automatic logic [9:0] scroll_step(input logic [9:0] x,
                                             input int step,
                                             input logic forward);
    int s;
    s = forward ? int'(x) + step : int'(x) - step;
    if (s >= H_ACTIVE) begin
      s = s - H_ACTIVE;
    end else if (s < 0) begin
      s = s + H_ACTIVE;
    end
    return 10'(s);
  endfunction

endpackage

// File: rtl/pattern_ctrl_if.sv
// pattern_ctrl_if -- button/frame inputs and pattern outputs of pattern_ctrl.
//
// Signals:
//   btn_up/down/left/right  raw asynchronous push buttons, active-high
//   frame_start             one-cycle pulse at start of vertical blanking
//   pattern_sel[2:0]        selected pattern index
//   scroll_x[9:0]           horizontal pattern offset, 0..639
//   update_pulse            one-cycle pulse when pattern_sel or scroll_x changed
//   auto_active             high while the controller auto-cycles
//
// Modports:
//   master  drives buttons and frame_start, observes the outputs
//   slave   the controller side (pattern_ctrl)
interface pattern_ctrl_if;

  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       frame_start;
  logic [2:0] pattern_sel;
  logic [9:0] scroll_x;
  logic       update_pulse;
  logic       auto_active;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, frame_start,
    input  pattern_sel, scroll_x, update_pulse, auto_active
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, frame_start,
    output pattern_sel, scroll_x, update_pulse, auto_active
  );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce -- synchronizer, debouncer and press detector for one button.
//
// Ports:
//   clk      clock
//   reset    asynchronous, active-high reset (clears synchronizer, count, level)
//   btn_raw  raw asynchronous button, active-high
//   press    one-cycle pulse when the accepted level goes 0 -> 1
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive identical synchronized samples needed before
//                    the accepted level follows the button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_ff;
  logic [CNT_W-1:0] cnt;
  logic             level;

  // cnt holds how many consecutive samples have disagreed with the accepted
  // level; any agreeing sample restarts it. The sample that completes the run
  // flips the level and, for a rising level, fires press in the same update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff <= 2'b00;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], btn_raw};
      press   <= 1'b0;
      if (sync_ff[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_ff[1];
        press <= sync_ff[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pattern_ctrl.sv
// pattern_ctrl -- button-driven selector of VGA test pattern and scroll offset.
//
// Ports:
//   clk    pixel clock
//   reset  asynchronous, active-high reset
//   bus    pattern_ctrl_if.slave: buttons, frame_start in; pattern_sel,
//          scroll_x, update_pulse, auto_active out
//
// Button presses are collected as pending flags and applied only on a
// frame_start cycle, so outputs change exclusively on the edge after
// frame_start. Opposing presses in the same frame cancel.
//
// Build option PATTERN_CTRL_AUTO_CYCLE_EN: after AUTO_FRAMES consecutive frames
// without pending presses the controller enters AUTO and steps pattern_sel
// every AUTO_FRAMES frames until a button is pressed. Without the macro the
// controller is always MANUAL and auto_active is constant 0.
module pattern_ctrl
  import vga_pkg::*;
#(
  parameter int NUM_PATTERNS    = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SCROLL_STEP     = 8,
  parameter int AUTO_FRAMES     = 300
) (
  input  logic clk,
  input  logic reset,
  pattern_ctrl_if.slave bus
);

  localparam logic [2:0] PAT_LAST = 3'(NUM_PATTERNS - 1);

  logic [3:0] press;
  logic [3:0] pending;
  logic [2:0] pattern_sel_q;
  logic [2:0] pattern_next;
  logic [9:0] scroll_x_q;
  logic [9:0] scroll_next;
  logic       update_pulse_q;
  logic       auto_step;

  function automatic logic [2:0] pattern_inc(input logic [2:0] p);
    return (p == PAT_LAST) ? 3'd0 : p + 3'd1;
  endfunction

  function automatic logic [2:0] pattern_dec(input logic [2:0] p);
    return (p == 3'd0) ? PAT_LAST : p - 3'd1;
  endfunction

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk(clk), .reset(reset), .btn_raw(bus.btn_up), .press(press[BTN_UP])
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk(clk), .reset(reset), .btn_raw(bus.btn_down), .press(press[BTN_DOWN])
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk(clk), .reset(reset), .btn_raw(bus.btn_left), .press(press[BTN_LEFT])
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk(clk), .reset(reset), .btn_raw(bus.btn_right), .press(press[BTN_RIGHT])
  );

  // Values the outputs take if the current cycle is a frame_start. An auto
  // step only happens in AUTO with no press, so pending is empty then and the
  // two sources never compete.
  always_comb begin
    pattern_next = pattern_sel_q;
    scroll_next  = scroll_x_q;
    if (auto_step) begin
      pattern_next = pattern_inc(pattern_sel_q);
    end else begin
      if (pending[BTN_UP] && !pending[BTN_DOWN]) begin
        pattern_next = pattern_inc(pattern_sel_q);
      end else if (pending[BTN_DOWN] && !pending[BTN_UP]) begin
        pattern_next = pattern_dec(pattern_sel_q);
      end
      if (pending[BTN_RIGHT] && !pending[BTN_LEFT]) begin
        scroll_next = scroll_step(scroll_x_q, SCROLL_STEP, 1'b1);
      end else if (pending[BTN_LEFT] && !pending[BTN_RIGHT]) begin
        scroll_next = scroll_step(scroll_x_q, SCROLL_STEP, 1'b0);
      end
    end
  end

  // On frame_start the flags are consumed, but a press arriving in that very
  // cycle becomes the new pending set so it lands on the following frame.
  // update_pulse compares against the old values so a cancel stays silent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending        <= 4'b0000;
      pattern_sel_q  <= 3'd0;
      scroll_x_q     <= 10'd0;
      update_pulse_q <= 1'b0;
    end else begin
      update_pulse_q <= 1'b0;
      if (bus.frame_start) begin
        pending        <= press;
        pattern_sel_q  <= pattern_next;
        scroll_x_q     <= scroll_next;
        update_pulse_q <= (pattern_next != pattern_sel_q) ||
                          (scroll_next != scroll_x_q);
      end else begin
        pending <= pending | press;
      end
    end
  end

  assign bus.pattern_sel  = pattern_sel_q;
  assign bus.scroll_x     = scroll_x_q;
  assign bus.update_pulse = update_pulse_q;

`ifdef PATTERN_CTRL_AUTO_CYCLE_EN
  localparam int IDLE_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(AUTO_FRAMES - 1);

  ctrl_state_t       state;
  logic [IDLE_W-1:0] idle_cnt;
  logic              auto_active_q;
  logic              any_press;

  assign any_press = |press;
  assign auto_step = bus.frame_start && (state == ST_AUTO) && !any_press &&
                     (idle_cnt == IDLE_LAST);

  // idle_cnt counts frames in MANUAL without pending presses and, once in
  // AUTO, frames until the next pattern step. Any press wins over a
  // coincident frame_start: back to MANUAL with the count restarted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_MANUAL;
      idle_cnt      <= '0;
      auto_active_q <= 1'b0;
    end else if (any_press) begin
      state         <= ST_MANUAL;
      idle_cnt      <= '0;
      auto_active_q <= 1'b0;
    end else if (bus.frame_start) begin
      case (state)
        ST_MANUAL: begin
          if (|pending) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state         <= ST_AUTO;
            idle_cnt      <= '0;
            auto_active_q <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_AUTO: begin
          if (idle_cnt == IDLE_LAST) begin
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: begin
          state         <= ST_MANUAL;
          idle_cnt      <= '0;
          auto_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.auto_active = auto_active_q;
`else
  // Auto-cycle compiled out. AUTO_FRAMES is never negative, so auto_active
  // is a constant 0.
  assign auto_step       = 1'b0;
  assign bus.auto_active = (AUTO_FRAMES < 0);
`endif

endmodule
